// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM encoding, frame geometry, line levels.
// Latency: n/a (types and constants only). Backpressure: n/a.
package uart_pkg;
  localparam int   UART_DATA_BITS   = 8;
  localparam int   CLKS_PER_BIT_DEF = 868;
  localparam logic STOP_LEVEL       = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_done on the last cycle of every CLKS_PER_BIT-cycle bit.
// Latency: first pulse CLKS_PER_BIT cycles after clr drops. Backpressure: none, clr holds it at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_cnt;

  assign bit_done = !clr && (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (clr || bit_done) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte and sends it as an 8N1 frame (8E1 when UART_PARITY_EN is defined).
// Latency: tx falls two edges after IDLE accepts a byte. Backpressure: pops only in IDLE with tx_en and fifo_cnt!=0.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] fifo_cnt,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);
  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       baud_clr;
  logic       bit_done;
`ifdef UART_PARITY_EN
  logic       parity;
`endif

  // Bit timer only runs while a bit is on the line; LOAD clears it so START gets a full period.
  assign baud_clr = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (baud_clr),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= STOP_LEVEL;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
`ifdef UART_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tx_en && (fifo_cnt != 8'd0)) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          fifo_rd_en <= 1'b0;
          state      <= LOAD;
        end
        LOAD: begin
          shreg   <= fifo_data;
`ifdef UART_PARITY_EN
          parity  <= ^fifo_data;
`endif
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_done) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= STOP_LEVEL;
              state <= STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            tx    <= STOP_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= STOP_LEVEL;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a 1-cycle-latency FIFO model.
// Frame length follows UART_PARITY_EN when that macro is defined.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] fifo_cnt;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  int         pops = 0;
  int         checks = 0;
  int         errors = 0;
  int         n;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .fifo_cnt  (fifo_cnt),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  assign fifo_cnt = wr_ptr - rd_ptr;

  // FIFO model: data_out updates on the edge that samples rd_en
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
      pops      <= pops + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_fall(output int cnt);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("fall_timeout", (cnt < 200) ? 1 : 0, 1);
  endtask

  // Checks one whole frame cycle by cycle; optionally drops tx_en mid data bit.
  task automatic frame(input logic [7:0] b, input string tag, input int drop_bit, output int wcnt);
    logic expb;
    wait_fall(wcnt);
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)                         expb = 1'b0;
      else if (k <= 8)                    expb = b[k-1];
      else if (NBITS == 11 && k == 9)     expb = ^b;
      else                                expb = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (k == drop_bit && c == 1) tx_en = 1'b0;
        chk($sformatf("%s_bit%0d_c%0d", tag, k, c), tx, expb);
      end
      chk($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
    end
  endtask

  initial begin
    // 1: reset with data waiting
    rst_n = 1'b0;
    tx_en = 1'b1;
    wr_ptr = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
    end
    wr_ptr = 8'd0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_empty_tx", tx, 1'b1);
    chk("idle_empty_busy", busy, 1'b0);
    chk("idle_empty_pops", pops, 0);

    // 2: single byte 0xA5, latency and busy window
    push(8'hA5);
    @(negedge clk);
    chk("a5_rd_en_hi", fifo_rd_en, 1'b1);
    chk("a5_busy_fetch", busy, 1'b1);
    chk("a5_tx_fetch", tx, 1'b1);
    @(negedge clk);
    chk("a5_rd_en_lo", fifo_rd_en, 1'b0);
    chk("a5_busy_load", busy, 1'b1);
    chk("a5_tx_load", tx, 1'b1);
    @(negedge clk);
    chk("a5_tx_fall", tx, 1'b0);
    frame(8'hA5, "a5", -1, n);
    chk("a5_fall_wait", n, 0);
    @(negedge clk);
    chk("a5_busy_end", busy, 1'b0);
    chk("a5_tx_end", tx, 1'b1);
    chk("a5_pops", pops, 1);

    // 3: back-to-back frames and inter-frame gap
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    frame(8'h00, "b00", -1, n);
    chk("b00_latency", n, 3);
    frame(8'hFF, "bff", -1, n);
    chk("bff_gap", CPB + n - 1, 7);
    frame(8'h55, "b55", -1, n);
    chk("b55_gap", CPB + n - 1, 7);
    chk("b3_pops", pops, 4);
    @(negedge clk);
    chk("b3_busy_end", busy, 1'b0);

    // 4: tx_en dropped during data bit 3 of 0x3C
    push(8'h3C);
    push(8'h81);
    frame(8'h3C, "c3c", 4, n);
    chk("c3c_latency", n, 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("hold_tx", tx, 1'b1);
      chk("hold_rd_en", fifo_rd_en, 1'b0);
      chk("hold_busy", busy, 1'b0);
    end
    chk("hold_pops", pops, 5);
    tx_en = 1'b1;
    frame(8'h81, "c81", -1, n);
    chk("c81_latency", n, 3);
    chk("c81_pops", pops, 6);

    // 5: reset during data bit 5 of 0x96
    push(8'h96);
    push(8'h4B);
    wait_fall(n);
    repeat (25) @(negedge clk);
    chk("r96_bit5", tx, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rd_en", fifo_rd_en, 1'b0);
    end
    rst_n = 1'b1;
    frame(8'h4B, "r4b", -1, n);
    chk("r4b_latency", n, 3);
    chk("r4b_pops", pops, 8);
    @(negedge clk);
    chk("r4b_busy_end", busy, 1'b0);

`ifdef UART_PARITY_EN
    // 6: even parity bit
    push(8'h07);
    push(8'h03);
    frame(8'h07, "p07", -1, n);
    frame(8'h03, "p03", -1, n);
    chk("p03_gap", CPB + n - 1, 7);
    chk("par_pops", pops, 10);
    @(negedge clk);
    chk("par_busy_end", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
